alu_mdu: RTL

//  Execute-stage ALU for the MIPS core with decode, registered output and an iterative multiply/divide unit (HI/LO).

---
 rtl/mips_pkg.sv | 57 +++++
 rtl/mdu_iter.sv | 137 +++++++++++++
 rtl/alu_mdu.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: R-type funct codes, the
// internal ALU control codes, the ALUOp encoding and the multiply/divide
// sequencer state type.
// Optional feature macro: ALU_MDU_DIV_EN (adds the DIV sequencer state).
package mips_pkg;

    // ALUOp from the main decoder
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpRtype = 2'b10;

    // R-type funct field
    localparam logic [5:0] FnSll   = 6'b000000;
    localparam logic [5:0] FnSrl   = 6'b000010;
    localparam logic [5:0] FnSra   = 6'b000011;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnXor   = 6'b100110;
    localparam logic [5:0] FnNor   = 6'b100111;
    localparam logic [5:0] FnSlt   = 6'b101010;
    localparam logic [5:0] FnSltu  = 6'b101011;

    // ALU control: the classic codes plus extensions filling the free slots
    localparam logic [3:0] CtlAnd  = 4'b0000;
    localparam logic [3:0] CtlOr   = 4'b0001;
    localparam logic [3:0] CtlAdd  = 4'b0010;
    localparam logic [3:0] CtlXor  = 4'b0011;
    localparam logic [3:0] CtlMul  = 4'b0100;
    localparam logic [3:0] CtlDiv  = 4'b0101;
    localparam logic [3:0] CtlSub  = 4'b0110;
    localparam logic [3:0] CtlSlt  = 4'b0111;
    localparam logic [3:0] CtlSltu = 4'b1000;
    localparam logic [3:0] CtlSll  = 4'b1001;
    localparam logic [3:0] CtlSra  = 4'b1010;
    localparam logic [3:0] CtlMfhi = 4'b1011;
    localparam logic [3:0] CtlNor  = 4'b1100;
    localparam logic [3:0] CtlMflo = 4'b1101;
    localparam logic [3:0] CtlIll  = 4'b1110;
    localparam logic [3:0] CtlSrl  = 4'b1111;

`ifdef ALU_MDU_DIV_EN
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`endif

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath. Multiplies by shift-add and divides by
// restoring division, one bit per cycle, over WIDTH cycles. Works on operand
// magnitudes and applies the result signs on the output side.
// Optional feature macro: ALU_MDU_DIV_EN (without it only multiply exists).
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        load operands and begin (single cycle pulse)
//   signed_i       treat a_i/b_i as two's complement
//   op_i           0 multiply, 1 divide
//   a_i, b_i       operands (rs, rt)
//   done_o         high in the cycle the last step is taken
//   hi_o, lo_o     sign-corrected result, valid the cycle after done_o
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CNT_W = $clog2(WIDTH);

    // acc holds {partial product, multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step, prod_fix;

    assign sign_a = signed_i & a_i[WIDTH-1];
    assign sign_b = signed_i & b_i[WIDTH-1];
    assign mag_a  = sign_a ? -a_i : a_i;
    assign mag_b  = sign_b ? -b_i : b_i;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;

    assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_MDU_DIV_EN
    logic               op_q, op_d;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_step;

    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    // Borrow out means the divisor did not fit: keep the shifted remainder
    assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`else
    logic unused_op;
    assign unused_op = op_i;
`endif

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
`ifdef ALU_MDU_DIV_EN
        op_d     = op_q;
`endif
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, mag_b};
            opnd_d   = mag_a;
            neg_hi_d = sign_a ^ sign_b;
            neg_lo_d = sign_a ^ sign_b;
`ifdef ALU_MDU_DIV_EN
            op_d = op_i;
            if (op_i) begin
                acc_d    = {{WIDTH{1'b0}}, mag_a};
                opnd_d   = mag_b;
                neg_hi_d = sign_a;
            end
`endif
        end else if (busy_q) begin
            acc_d = mul_step;
`ifdef ALU_MDU_DIV_EN
            if (op_q) acc_d = div_step;
`endif
            cnt_d = cnt_q + 1'b1;
            if (done_o) busy_d = 1'b0;
        end
    end

    always_comb begin
        hi_o = prod_fix[2*WIDTH-1:WIDTH];
        lo_o = prod_fix[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
        if (op_q) begin
            hi_o = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_o = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            op_q     <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
`ifdef ALU_MDU_DIV_EN
            op_q     <= op_d;
`endif
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with R-type decode, valid/ready handshake, registered
// result and HI/LO registers fed by an iterative multiply/divide unit.
// Optional feature macro: ALU_MDU_DIV_EN (DIV/DIVU; otherwise decoded illegal).
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / o_ready     operation offered / can be accepted
//   i_alu_op, i_func      ALUOp and R-type funct
//   i_shamt, i_a, i_b     shift amount, operands (rs, rt)
//   o_valid / i_ready     result valid / consumer takes result
//   o_result, o_zero      registered result, result == 0
//   o_illegal             unknown funct, qualified by o_valid
module alu_mdu
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_alu_op,
    input  logic [5:0]         i_func,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_zero,
    output logic               o_illegal
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic             valid_q, valid_d, illegal_q, illegal_d;

    logic [3:0]       ctl;
    logic             is_signed, accept, mdu_start, mdu_done;
    logic [WIDTH-1:0] alu_res, mdu_hi, mdu_lo;

    assign o_ready   = (state_q == StIdle) && (!valid_q || i_ready);
    assign accept    = i_valid && o_ready;
    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_zero    = (result_q == '0);
    assign o_illegal = valid_q && illegal_q;

    always_comb begin
        ctl       = CtlAdd;
        is_signed = 1'b0;
        case (i_alu_op)
            AluOpSub: ctl = CtlSub;
            AluOpRtype: begin
                case (i_func)
                    FnAdd, FnAddu: ctl = CtlAdd;
                    FnSub, FnSubu: ctl = CtlSub;
                    FnAnd:         ctl = CtlAnd;
                    FnOr:          ctl = CtlOr;
                    FnXor:         ctl = CtlXor;
                    FnNor:         ctl = CtlNor;
                    FnSlt:         ctl = CtlSlt;
                    FnSltu:        ctl = CtlSltu;
                    FnSll:         ctl = CtlSll;
                    FnSrl:         ctl = CtlSrl;
                    FnSra:         ctl = CtlSra;
                    FnMfhi:        ctl = CtlMfhi;
                    FnMflo:        ctl = CtlMflo;
                    FnMult: begin
                        ctl       = CtlMul;
                        is_signed = 1'b1;
                    end
                    FnMultu:       ctl = CtlMul;
`ifdef ALU_MDU_DIV_EN
                    FnDiv: begin
                        ctl       = CtlDiv;
                        is_signed = 1'b1;
                    end
                    FnDivu:        ctl = CtlDiv;
`endif
                    default:       ctl = CtlIll;
                endcase
            end
            default: ctl = CtlAdd;
        endcase
    end

    always_comb begin
        case (ctl)
            CtlAnd:  alu_res = i_a & i_b;
            CtlOr:   alu_res = i_a | i_b;
            CtlXor:  alu_res = i_a ^ i_b;
            CtlNor:  alu_res = ~(i_a | i_b);
            CtlAdd:  alu_res = i_a + i_b;
            CtlSub:  alu_res = i_a - i_b;
            CtlSlt:  alu_res = WIDTH'($signed(i_a) < $signed(i_b));
            CtlSltu: alu_res = WIDTH'(i_a < i_b);
            CtlSll:  alu_res = i_b << i_shamt;
            CtlSrl:  alu_res = i_b >> i_shamt;
            CtlSra:  alu_res = WIDTH'($signed(i_b) >>> i_shamt);
            CtlMfhi: alu_res = hi_q;
            CtlMflo: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        mdu_start = 1'b0;
        if (valid_q && i_ready) valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (ctl == CtlMul) begin
                        mdu_start = 1'b1;
                        state_d   = StMul;
                        valid_d   = 1'b0;
`ifdef ALU_MDU_DIV_EN
                    end else if (ctl == CtlDiv && i_b == '0) begin
                        // Divide by zero completes at once without the divider
                        lo_d      = '1;
                        hi_d      = i_a;
                        result_d  = '1;
                        illegal_d = 1'b0;
                        valid_d   = 1'b1;
                    end else if (ctl == CtlDiv) begin
                        mdu_start = 1'b1;
                        state_d   = StDiv;
                        valid_d   = 1'b0;
`endif
                    end else begin
                        result_d  = alu_res;
                        illegal_d = (ctl == CtlIll);
                        valid_d   = 1'b1;
                    end
                end
            end
`ifdef ALU_MDU_DIV_EN
            StMul, StDiv: if (mdu_done) state_d = StDone;
`else
            StMul: if (mdu_done) state_d = StDone;
`endif
            StDone: begin
                hi_d      = mdu_hi;
                lo_d      = mdu_lo;
                result_d  = mdu_lo;
                illegal_d = 1'b0;
                valid_d   = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu_iter (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .start_i (mdu_start),
        .signed_i(is_signed),
        .op_i    (ctl == CtlDiv),
        .a_i     (i_a),
        .b_i     (i_b),
        .done_o  (mdu_done),
        .hi_o    (mdu_hi),
        .lo_o    (mdu_lo)
    );

endmodule
